// File: rtl/counter_checker_if.sv
// -----------------------------------------------------------------------------
// counter_checker_if
//   Bundles the signals a counter_checker observes (the counter's stimulus and
//   its count output) together with the verdict/coverage results it reports.
//
//   master : drives the observed counter signals and reads the verdicts
//            (testbench / fuzz harness side)
//   slave  : the checker itself
//
//   Observed : dut_reset, up_down, count[WIDTH], chk_en
//   Results  : synced, fail, err_cnt[ERR_W], cyc_cnt[CYC_W],
//              first_err_cyc[CYC_W], first_err_exp[WIDTH], first_err_act[WIDTH],
//              cov_wrap_up, cov_wrap_dn, cov_reset, cov_done
// -----------------------------------------------------------------------------
interface counter_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8,
    parameter int CYC_W = 16
) ();
    logic             dut_reset;
    logic             up_down;
    logic [WIDTH-1:0] count;
    logic             chk_en;

    logic             synced;
    logic             fail;
    logic [ERR_W-1:0] err_cnt;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] first_err_cyc;
    logic [WIDTH-1:0] first_err_exp;
    logic [WIDTH-1:0] first_err_act;
    logic             cov_wrap_up;
    logic             cov_wrap_dn;
    logic             cov_reset;
    logic             cov_done;

    modport master (
        output dut_reset, up_down, count, chk_en,
        input  synced, fail, err_cnt, cyc_cnt, first_err_cyc, first_err_exp,
               first_err_act, cov_wrap_up, cov_wrap_dn, cov_reset, cov_done
    );

    modport slave (
        input  dut_reset, up_down, count, chk_en,
        output synced, fail, err_cnt, cyc_cnt, first_err_cyc, first_err_exp,
               first_err_act, cov_wrap_up, cov_wrap_dn, cov_reset, cov_done
    );
endinterface

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//   Lock-step monitor for an up/down counter. A reference model of the counter
//   tracks the observed stimulus; once aligned by a dut_reset it compares the
//   counter's count against the model every enabled cycle, counts mismatches,
//   captures the first failure and collects wrap/reset coverage bins.
//
//   Ports
//     clk   : checker clock (same clock as the counter)
//     reset : asynchronous active-low reset of the checker
//     mon   : counter_checker_if.slave - observed counter signals in,
//             verdict and coverage results out (all registered)
//
//   Parameters
//     WIDTH  : counter width; the model wraps modulo 2^WIDTH
//     ERR_W  : width of the saturating mismatch counter
//     CYC_W  : width of the saturating compared-cycle counter
//     RESYNC : 1 = after a mismatch the model reloads from the observed count
// -----------------------------------------------------------------------------
module counter_checker #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int CYC_W  = 16,
    parameter int RESYNC = 1
) (
    input  logic               clk,
    input  logic               reset,
    counter_checker_if.slave   mon
);

    localparam logic [1:0] ST_UNSYNC = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;

    localparam logic [WIDTH-1:0] W_ONE   = WIDTH'(1);
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

    // Reference counter function: reset dominates, otherwise +/-1 with wrap.
    function automatic logic [WIDTH-1:0] f_next(
        input logic [WIDTH-1:0] v,
        input logic             r,
        input logic             d
    );
        logic [WIDTH-1:0] res;
        if (r)      res = '0;
        else if (d) res = v + W_ONE;
        else        res = v - W_ONE;
        return res;
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_exp;
    logic             r_synced;
    logic             r_fail;
    logic [ERR_W-1:0] r_err_cnt;
    logic [CYC_W-1:0] r_cyc_cnt;
    logic [CYC_W-1:0] r_first_err_cyc;
    logic [WIDTH-1:0] r_first_err_exp;
    logic [WIDTH-1:0] r_first_err_act;
    logic             r_cov_wrap_up;
    logic             r_cov_wrap_dn;
    logic             r_cov_reset;
    logic             r_cov_done;

    logic             w_in_check;
    logic             w_cmp;
    logic             w_mis;
    logic [WIDTH-1:0] w_exp_base;
    logic [WIDTH-1:0] w_exp_next;
    logic             w_hit_up;
    logic             w_hit_dn;
    logic             w_hit_rst;
    logic             w_cov_up_nxt;
    logic             w_cov_dn_nxt;
    logic             w_cov_rst_nxt;

    assign w_in_check = (r_state == ST_CHECK);
    assign w_cmp      = w_in_check & mon.chk_en;
    // Both sides are the pre-edge values: count is what the counter holds now,
    // r_exp is what the model predicted for now.
    assign w_mis      = w_cmp & (mon.count != r_exp);

    // On a mismatch with RESYNC the model adopts the observed count before
    // stepping, so one glitch does not cascade into a stream of errors.
    assign w_exp_base = (w_mis && (RESYNC != 0)) ? mon.count : r_exp;
    assign w_exp_next = f_next(w_exp_base, mon.dut_reset, mon.up_down);

    // Coverage uses the model value so it is immune to a faulty counter, and
    // is collected whether or not compares are enabled.
    assign w_hit_up  = w_in_check & ~mon.dut_reset &  mon.up_down & (r_exp == '1);
    assign w_hit_dn  = w_in_check & ~mon.dut_reset & ~mon.up_down & (r_exp == '0);
    assign w_hit_rst = w_in_check &  mon.dut_reset;

    assign w_cov_up_nxt  = r_cov_wrap_up | w_hit_up;
    assign w_cov_dn_nxt  = r_cov_wrap_dn | w_hit_dn;
    assign w_cov_rst_nxt = r_cov_reset   | w_hit_rst;

    // State machine and model value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_UNSYNC;
            r_exp    <= '0;
            r_synced <= 1'b0;
        end else begin
            case (r_state)
                ST_UNSYNC: begin
                    if (mon.dut_reset) begin
                        r_state  <= ST_SYNC;
                        r_exp    <= '0;
                        r_synced <= 1'b1;
                    end
                end
                // The counter's reset edge has just happened; count only
                // becomes meaningful from the next edge on, so step the
                // model once without comparing.
                ST_SYNC: begin
                    r_state <= ST_CHECK;
                    r_exp   <= f_next(r_exp, mon.dut_reset, mon.up_down);
                end
                ST_CHECK: begin
                    r_exp <= w_exp_next;
                end
                default: begin
                    r_state  <= ST_UNSYNC;
                    r_exp    <= '0;
                    r_synced <= 1'b0;
                end
            endcase
        end
    end

    // Compare bookkeeping: saturating counters and first-failure capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fail          <= 1'b0;
            r_err_cnt       <= '0;
            r_cyc_cnt       <= '0;
            r_first_err_cyc <= '0;
            r_first_err_exp <= '0;
            r_first_err_act <= '0;
        end else begin
            if (w_cmp && (r_cyc_cnt != '1)) begin
                r_cyc_cnt <= r_cyc_cnt + CYC_ONE;
            end
            if (w_mis) begin
                r_fail <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_ONE;
                end
                if (!r_fail) begin
                    r_first_err_cyc <= r_cyc_cnt;
                    r_first_err_exp <= r_exp;
                    r_first_err_act <= mon.count;
                end
            end
        end
    end

    // Sticky coverage bins; cov_done is registered from the next-state bins
    // so it lines up with the individual bins on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cov_wrap_up <= 1'b0;
            r_cov_wrap_dn <= 1'b0;
            r_cov_reset   <= 1'b0;
            r_cov_done    <= 1'b0;
        end else begin
            r_cov_wrap_up <= w_cov_up_nxt;
            r_cov_wrap_dn <= w_cov_dn_nxt;
            r_cov_reset   <= w_cov_rst_nxt;
            r_cov_done    <= w_cov_up_nxt & w_cov_dn_nxt & w_cov_rst_nxt;
        end
    end

    assign mon.synced        = r_synced;
    assign mon.fail          = r_fail;
    assign mon.err_cnt       = r_err_cnt;
    assign mon.cyc_cnt       = r_cyc_cnt;
    assign mon.first_err_cyc = r_first_err_cyc;
    assign mon.first_err_exp = r_first_err_exp;
    assign mon.first_err_act = r_first_err_act;
    assign mon.cov_wrap_up   = r_cov_wrap_up;
    assign mon.cov_wrap_dn   = r_cov_wrap_dn;
    assign mon.cov_reset     = r_cov_reset;
    assign mon.cov_done      = r_cov_done;

endmodule

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
//   Drives two checkers (RESYNC=1 and RESYNC=0) with the same counter trace.
//   A behavioural model predicts each checker's outputs; predictions are
//   queued when stimulus is applied and popped once the edge has been taken.
//   Directed checks pin the key values from the test plan as constants.
// -----------------------------------------------------------------------------
module tb_counter_checker;

    typedef struct packed {
        logic        synced;
        logic        fail;
        logic [7:0]  err;
        logic [15:0] cyc;
        logic [15:0] fcyc;
        logic [3:0]  fexp;
        logic [3:0]  fact;
        logic        cwu;
        logic        cwd;
        logic        cr;
        logic        cdone;
    } obs_t;

    typedef struct packed {
        logic [1:0] st;   // 0 unsync, 1 sync, 2 check
        logic [3:0] exp;
        obs_t       o;
    } mdl_t;

    logic clk;
    logic reset;

    counter_checker_if #(.WIDTH(4), .ERR_W(8), .CYC_W(16)) if1 ();
    counter_checker_if #(.WIDTH(4), .ERR_W(8), .CYC_W(16)) if0 ();

    counter_checker #(.WIDTH(4), .ERR_W(8), .CYC_W(16), .RESYNC(1)) dut1 (
        .clk(clk), .reset(reset), .mon(if1.slave));
    counter_checker #(.WIDTH(4), .ERR_W(8), .CYC_W(16), .RESYNC(0)) dut0 (
        .clk(clk), .reset(reset), .mon(if0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t o1, o0;
    always_comb begin
        o1 = '{synced:if1.synced, fail:if1.fail, err:if1.err_cnt, cyc:if1.cyc_cnt,
               fcyc:if1.first_err_cyc, fexp:if1.first_err_exp, fact:if1.first_err_act,
               cwu:if1.cov_wrap_up, cwd:if1.cov_wrap_dn, cr:if1.cov_reset, cdone:if1.cov_done};
        o0 = '{synced:if0.synced, fail:if0.fail, err:if0.err_cnt, cyc:if0.cyc_cnt,
               fcyc:if0.first_err_cyc, fexp:if0.first_err_exp, fact:if0.first_err_act,
               cwu:if0.cov_wrap_up, cwd:if0.cov_wrap_dn, cr:if0.cov_reset, cdone:if0.cov_done};
    end

    int   errors = 0;
    int   checks = 0;
    mdl_t m1, m0;
    obs_t q1[$];
    obs_t q0[$];
    logic [3:0] cnt;   // the "real" counter value as it would be registered

    function automatic logic [3:0] ff(input logic [3:0] v, input logic r, input logic d);
        if (r) return 4'd0;
        return d ? v + 4'd1 : v - 4'd1;
    endfunction

    // Behavioural prediction of one checker edge.
    function automatic mdl_t mstep(input mdl_t m, input bit rs, input logic dr,
                                   input logic ud, input logic [3:0] c, input logic en);
        mdl_t n;
        bit   mis;
        n = m;
        if (m.st == 2'd0) begin
            if (dr) begin
                n.st = 2'd1; n.exp = 4'd0; n.o.synced = 1'b1;
            end
        end else if (m.st == 2'd1) begin
            n.st = 2'd2; n.exp = ff(m.exp, dr, ud);
        end else begin
            mis = en && (c != m.exp);
            if (en && m.o.cyc != 16'hffff) n.o.cyc = m.o.cyc + 16'd1;
            if (mis) begin
                n.o.fail = 1'b1;
                if (m.o.err != 8'hff) n.o.err = m.o.err + 8'd1;
                if (!m.o.fail) begin
                    n.o.fcyc = m.o.cyc; n.o.fexp = m.exp; n.o.fact = c;
                end
            end
            n.exp = ff((mis && rs) ? c : m.exp, dr, ud);
            if (!dr && ud && m.exp == 4'hf) n.o.cwu = 1'b1;
            if (!dr && !ud && m.exp == 4'h0) n.o.cwd = 1'b1;
            if (dr) n.o.cr = 1'b1;
            n.o.cdone = n.o.cwu & n.o.cwd & n.o.cr;
        end
        return n;
    endfunction

    task automatic chk_obs(input string tag, input obs_t act, input obs_t exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // One clock: apply inputs, predict, take the edge, compare.
    task automatic tick(input logic dr, input logic ud, input logic en, input logic [3:0] c);
        obs_t e1, e0;
        if1.dut_reset = dr; if1.up_down = ud; if1.chk_en = en; if1.count = c;
        if0.dut_reset = dr; if0.up_down = ud; if0.chk_en = en; if0.count = c;
        m1 = mstep(m1, 1'b1, dr, ud, c, en);
        m0 = mstep(m0, 1'b0, dr, ud, c, en);
        q1.push_back(m1.o);
        q0.push_back(m0.o);
        @(posedge clk);
        @(negedge clk);
        e1 = q1.pop_front();
        e0 = q0.pop_front();
        chk_obs("step_resync1", o1, e1);
        chk_obs("step_resync0", o0, e0);
    endtask

    // A well-behaved counter edge.
    task automatic run(input logic dr, input logic ud, input logic en);
        tick(dr, ud, en, cnt);
        cnt = ff(cnt, dr, ud);
    endtask

    task automatic chk_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_obs("async_reset_r1", o1, obs_t'(0));
        chk_obs("async_reset_r0", o0, obs_t'(0));
        m1 = '0; m0 = '0;
        q1.delete(); q0.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] rnd;
        reset = 1'b0;
        if1.dut_reset = 1'b0; if1.up_down = 1'b0; if1.chk_en = 1'b1; if1.count = 4'd0;
        if0.dut_reset = 1'b0; if0.up_down = 1'b0; if0.chk_en = 1'b1; if0.count = 4'd0;
        cnt = 4'd0;
        m1 = '0; m0 = '0;
        #1;
        chk_obs("reset_state", o1, obs_t'(0));
        @(negedge clk);
        reset = 1'b1;

        // Phase 1: no dut_reset, garbage count -> never synced, nothing compared.
        for (int i = 0; i < 20; i++) begin
            rnd = 4'($urandom_range(0, 15));
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b1, rnd);
        end
        chk_val("unsync_synced", 16'(if1.synced), 16'd0);
        chk_val("unsync_cyc", if1.cyc_cnt, 16'd0);
        chk_val("unsync_fail", 16'(if1.fail), 16'd0);

        // Phase 2: align, count up through the 15 -> 0 wrap.
        run(1'b1, 1'b0, 1'b1);
        run(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 18; i++) run(1'b0, 1'b1, 1'b1);
        // chk_en low with a corrupted count: no compare, no error.
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0, cnt ^ 4'h8);
            cnt = ff(cnt, 1'b0, 1'b1);
        end
        chk_val("up_synced", 16'(if1.synced), 16'd1);
        chk_val("up_fail", 16'(if1.fail), 16'd0);
        chk_val("up_wrap_up", 16'(if1.cov_wrap_up), 16'd1);
        chk_val("up_wrap_dn", 16'(if1.cov_wrap_dn), 16'd0);
        chk_val("up_cyc", if1.cyc_cnt, 16'd18);

        // Phase 3: reset in CHECK, then down through 0 -> 15 -> 14, then reset.
        run(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) run(1'b0, 1'b0, 1'b1);
        chk_val("dn_wrap_dn", 16'(if1.cov_wrap_dn), 16'd1);
        run(1'b1, 1'b0, 1'b1);
        chk_val("cov_reset", 16'(if1.cov_reset), 16'd1);
        chk_val("cov_done", 16'(if1.cov_done), 16'd1);

        // Phase 4: fresh run, dut_reset in SYNC, glitch to 5 at compare 7.
        chk_reset();
        run(1'b1, 1'b0, 1'b1);
        run(1'b1, 1'b1, 1'b1);
        run(1'b0, 1'b1, 1'b1); run(1'b0, 1'b1, 1'b1); run(1'b0, 1'b1, 1'b1);
        run(1'b0, 1'b0, 1'b1); run(1'b0, 1'b1, 1'b1); run(1'b0, 1'b0, 1'b1);
        run(1'b0, 1'b1, 1'b1);
        cnt = 4'd5;
        run(1'b0, 1'b1, 1'b1);
        chk_val("glitch_err_r1", 16'(if1.err_cnt), 16'd1);
        chk_val("first_cyc", if1.first_err_cyc, 16'd7);
        chk_val("first_exp", 16'(if1.first_err_exp), 16'd3);
        chk_val("first_act", 16'(if1.first_err_act), 16'd5);
        for (int i = 0; i < 10; i++) run(1'b0, 1'b1, 1'b1);
        chk_val("after_err_r1", 16'(if1.err_cnt), 16'd1);
        chk_val("after_err_r0", 16'(if0.err_cnt), 16'd11);

        // Phase 5: 300 forced mismatches, saturation, first capture frozen.
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b1, 1'b1, cnt ^ 4'h1);
            cnt = ff(cnt, 1'b0, 1'b1);
        end
        chk_val("sat_err_r1", 16'(if1.err_cnt), 16'd255);
        chk_val("sat_err_r0", 16'(if0.err_cnt), 16'd255);
        chk_val("sat_first_cyc", if1.first_err_cyc, 16'd7);
        chk_val("sat_first_exp", 16'(if1.first_err_exp), 16'd3);
        chk_val("sat_first_act", 16'(if1.first_err_act), 16'd5);

        // Phase 6: asynchronous reset with fail set; no compares until dut_reset.
        chk_val("pre_reset_fail", 16'(if1.fail), 16'd1);
        chk_reset();
        for (int i = 0; i < 5; i++) begin
            rnd = 4'($urandom_range(0, 15));
            tick(1'b0, 1'b1, 1'b1, rnd);
        end
        chk_val("post_reset_synced", 16'(if1.synced), 16'd0);
        chk_val("post_reset_cyc", if1.cyc_cnt, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Self-checking monitor that sits directly downstream of the up/down counter.
- Each clock it observes the counter's reset and up_down inputs and its count output, and runs an internal reference model in lock-step.
- Reports mismatches, captures the first failure, and collects wrap/reset coverage bins.
- Used in fuzz regressions to turn raw count traces into pass/fail and coverage verdicts without file post-processing.

Parameters:
- WIDTH, 4, counter width in bits; the model wraps modulo 2^WIDTH.
- ERR_W, 8, width of the saturating error counter.
- CYC_W, 16, width of the checked-cycle counter and the first-fail cycle index.
- RESYNC, 1, 1 = after a mismatch the model reloads from the observed count; 0 = the model keeps its own value.

Ports:
- clk  input  1  checker clock, same clock as the counter.
- reset  input  1  asynchronous active-low reset of the checker itself.
- dut_reset  input  1  counter's synchronous active-high reset, as driven to the counter.
- up_down  input  1  counter direction as driven to the counter: 1 = increment, 0 = decrement.
- count  input  WIDTH  counter output (registered in the counter).
- chk_en  input  1  qualifies checking; when low, the model still tracks but no compare is made.
- synced  output  1  model aligned to the counter (a dut_reset has been observed).
- fail  output  1  sticky: at least one mismatch since checker reset.
- err_cnt  output  ERR_W  mismatch count, saturating at all-ones.
- cyc_cnt  output  CYC_W  number of compared cycles, saturating.
- first_err_cyc  output  CYC_W  cyc_cnt value at the first mismatch.
- first_err_exp  output  WIDTH  model value at the first mismatch.
- first_err_act  output  WIDTH  observed count at the first mismatch.
- cov_wrap_up  output  1  sticky: increment from all-ones to 0 seen.
- cov_wrap_dn  output  1  sticky: decrement from 0 to all-ones seen.
- cov_reset  output  1  sticky: dut_reset seen while synced.
- cov_done  output  1  AND of the three cov_* bins.

Behaviour:
- Reset (reset=0, asynchronous): all outputs and internal state are 0. State is UNSYNC and the model value is exp=0.
- Reference function: f(v, r, d) = 0 if r=1; else v+1 if d=1; else v-1. Wrap is modulo 2^WIDTH.
- The counter updates count <= f(count, dut_reset, up_down) on each rising edge. The checker samples the same values on the same edge.
- States:
  - UNSYNC: no compares, all counters held. On an edge with dut_reset=1: exp<=0, go to SYNC.
  - SYNC: one-edge wait state; count becomes valid after the counter's reset edge. exp<=f(exp, dut_reset, up_down). Go to CHECK.
  - CHECK: on each edge with chk_en=1:
    - compare count against exp (both the pre-edge values); cyc_cnt+1.
    - On mismatch: err_cnt+1, fail<=1. If fail was 0 before this edge, capture first_err_cyc=cyc_cnt (pre-increment), first_err_exp=exp, first_err_act=count.
- exp update in CHECK:
  - No mismatch, or RESYNC=0: exp<=f(exp, dut_reset, up_down).
  - Mismatch and RESYNC=1: exp<=f(count, dut_reset, up_down).
- synced is 1 in SYNC and CHECK.
- chk_en=0 in CHECK: exp still updates; no compare; cyc_cnt and err_cnt hold.
- Coverage, sampled only in CHECK, independent of chk_en, evaluated on exp (model) values:
  - cov_wrap_up when dut_reset=0, up_down=1, exp=all-ones.
  - cov_wrap_dn when dut_reset=0, up_down=0, exp=0.
  - cov_reset when dut_reset=1.
- Simultaneous dut_reset and mismatch on the same edge: the mismatch is recorded and exp<=0 (reset dominates).
- dut_reset in SYNC: exp<=0 and the state still advances to CHECK.
- Saturation: err_cnt and cyc_cnt stop at all-ones, with no wrap.
- Checker reset asserted mid-run: everything clears asynchronously and the checker returns to UNSYNC. It resynchronises only on the next dut_reset.
- Output latency: all outputs are registered and reflect the edge just taken.

Test Plan:
- No dut_reset for 20 cycles with random up_down, count=X: synced=0, cyc_cnt=0, fail=0 throughout.
- dut_reset=1 for 1 cycle, then up_down=1 for 18 cycles with a correct counter: synced=1, fail=0, cov_wrap_up=1 after count 15 to 0, cov_wrap_dn=0.
- After dut_reset, up_down=0 for 3 cycles: count goes 0 to 15 to 14; cov_wrap_dn=1. Then pulse dut_reset: cov_reset=1, cov_done=1 if the up wrap was also hit.
- Force count=5 when the model expects 3 at compare index 7, RESYNC=1: err_cnt=1, first_err_cyc=7, first_err_exp=3, first_err_act=5, no further errors if the counter then behaves. Same fault with RESYNC=0: err_cnt keeps growing.
- Inject 300 mismatches with ERR_W=8: err_cnt=255 and holds; first_err_* unchanged after the first capture.
- Assert checker reset (reset=0) mid-CHECK with fail=1: all outputs are 0 immediately, before the next clock edge. After release, no compares until the next dut_reset.
